// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the eight-lane TDM demultiplexer.
//   LANES   : number of time slots / output lanes per frame
//   SLOT_W  : width of a slot index
//   state_t : frame alignment state (HUNT for marker, LOCK to marker)
// -----------------------------------------------------------------------------
package tdm_pkg;

   localparam int LANES  = 8;
   localparam int SLOT_W = 3;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// -----------------------------------------------------------------------------
// tdm_slot_counter
// Slot index counter. It wraps modulo LANES and can be forced to 0 or to 1.
// Loading 1 is used on acquisition and realignment, because the marker sample
// that triggers those actions already occupies slot 0.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (slot -> 0)
//   adv   : advance the slot by one (7 wraps to 0)
//   load1 : force slot to 1 (takes priority over adv)
//   clear : force slot to 0 (takes priority over load1 and adv)
//   slot  : current slot index
//   last  : high when slot is the final slot of the frame
// -----------------------------------------------------------------------------
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              adv,
   input  logic              load1,
   input  logic              clear,
   output logic [SLOT_W-1:0] slot,
   output logic              last
);

   logic [SLOT_W-1:0] slot_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_reg <= '0;
      end else if (clear) begin
         slot_reg <= '0;
      end else if (load1) begin
         slot_reg <= SLOT_W'(1);
      end else if (adv) begin
         // LANES is a power of two, so natural overflow gives the wrap
         slot_reg <= slot_reg + SLOT_W'(1);
      end
   end

   assign slot = slot_reg;
   assign last = (slot_reg == SLOT_W'(LANES - 1));

endmodule

// File: rtl/tdm_demux8.sv
// -----------------------------------------------------------------------------
// tdm_demux8
// Eight-lane time-division demultiplexer. It aligns to a slot-0 frame marker,
// steers each serial bit into its lane, and presents each complete frame as a
// registered word with a one-cycle valid strobe. It also reports lock status
// and sync anomalies, and keeps a saturating anomaly count.
// Parameters:
//   MISS_LIMIT : consecutive missing slot-0 markers that drop lock (1..7)
//   ERR_W      : width of the saturating sync error counter
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   en          : sample enable; din/sync are consumed only when high
//   din         : serial data, one slot per enabled cycle
//   sync        : frame marker, high with the slot-0 bit
//   q           : last complete frame, q[i] = slot i bit
//   frame_valid : one-cycle pulse when q updates
//   locked      : high while aligned
//   slot        : slot index the next enabled sample will occupy
//   sync_err    : one-cycle pulse on any sync anomaly
//   err_count   : saturating count of sync_err pulses
// -----------------------------------------------------------------------------
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int MISS_LIMIT = 2,
   parameter int ERR_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              din,
   input  logic              sync,
   output logic [LANES-1:0]  q,
   output logic              frame_valid,
   output logic              locked,
   output logic [SLOT_W-1:0] slot,
   output logic              sync_err,
   output logic [ERR_W-1:0]  err_count
);

   state_t             state_reg, state_next;
   logic [LANES-1:0]   lane_reg,  lane_next;
   logic [LANES-1:0]   q_reg,     q_next;
   logic               fv_reg,    fv_next;
   logic               se_reg,    se_next;
   logic [ERR_W-1:0]   err_reg,   err_next;
   logic [2:0]         miss_reg,  miss_next;

   logic               cnt_adv;
   logic               cnt_load1;
   logic               cnt_clear;
   logic [SLOT_W-1:0]  slot_cnt;
   logic               slot_last;

   tdm_slot_counter u_slot (
      .clk   (clk),
      .rst   (rst),
      .adv   (cnt_adv),
      .load1 (cnt_load1),
      .clear (cnt_clear),
      .slot  (slot_cnt),
      .last  (slot_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= HUNT;
         lane_reg  <= '0;
         q_reg     <= '0;
         fv_reg    <= 1'b0;
         se_reg    <= 1'b0;
         err_reg   <= '0;
         miss_reg  <= '0;
      end else begin
         state_reg <= state_next;
         lane_reg  <= lane_next;
         q_reg     <= q_next;
         fv_reg    <= fv_next;
         se_reg    <= se_next;
         err_reg   <= err_next;
         miss_reg  <= miss_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      lane_next  = lane_reg;
      q_next     = q_reg;
      fv_next    = 1'b0;
      se_next    = 1'b0;
      miss_next  = miss_reg;
      cnt_adv    = 1'b0;
      cnt_load1  = 1'b0;
      cnt_clear  = 1'b0;

      if (en) begin
         unique case (state_reg)
            HUNT: begin
               if (sync) begin
                  lane_next  = {{(LANES-1){1'b0}}, din};
                  cnt_load1  = 1'b1;
                  miss_next  = '0;
                  state_next = LOCK;
               end
            end

            LOCK: begin
               if (slot_cnt == '0) begin
                  if (sync) begin
                     miss_next = '0;
                     lane_next = {{(LANES-1){1'b0}}, din};
                     cnt_adv   = 1'b1;
                  end else begin
                     se_next = 1'b1;
                     if (miss_reg == 3'(MISS_LIMIT - 1)) begin
                        // Too many consecutive misses: give up alignment
                        // and drop the frame that was just starting.
                        state_next = HUNT;
                        miss_next  = '0;
                        lane_next  = '0;
                        cnt_clear  = 1'b1;
                     end else begin
                        // A single miss is tolerated; the bit still counts
                        // as slot 0 so the frame can be delivered.
                        miss_next = miss_reg + 3'd1;
                        lane_next = {{(LANES-1){1'b0}}, din};
                        cnt_adv   = 1'b1;
                     end
                  end
               end else if (sync) begin
                  // Early marker: trust the marker, restart the frame here.
                  se_next   = 1'b1;
                  lane_next = {{(LANES-1){1'b0}}, din};
                  cnt_load1 = 1'b1;
                  miss_next = '0;
               end else begin
                  lane_next[slot_cnt] = din;
                  cnt_adv             = 1'b1;
                  if (slot_last) begin
                     q_next  = {din, lane_reg[LANES-2:0]};
                     fv_next = 1'b1;
                  end
               end
            end

            default: begin
               state_next = HUNT;
            end
         endcase
      end

      if (se_next && (err_reg != '1)) begin
         err_next = err_reg + ERR_W'(1);
      end else begin
         err_next = err_reg;
      end
   end

   assign q           = q_reg;
   assign frame_valid = fv_reg;
   assign locked      = (state_reg == LOCK);
   assign slot        = slot_cnt;
   assign sync_err    = se_reg;
   assign err_count   = err_reg;

endmodule

// File: tb/tb_tdm_demux8.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux8
// Directed bench for tdm_demux8 (MISS_LIMIT=2, ERR_W=2). Expected frames are
// queued with the cycle in which their frame_valid must appear. Every step
// checks frame_valid against that schedule and compares q on each delivery.
// -----------------------------------------------------------------------------
module tb_tdm_demux8;
   import tdm_pkg::*;

   localparam int MISS_LIMIT = 2;
   localparam int ERR_W      = 2;

   logic              clk;
   logic              rst;
   logic              en;
   logic              din;
   logic              sync;
   logic [LANES-1:0]  q;
   logic              frame_valid;
   logic              locked;
   logic [SLOT_W-1:0] slot;
   logic              sync_err;
   logic [ERR_W-1:0]  err_count;

   typedef struct {
      int         due;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   se_count = 0;
   int   fv_last  = -1;
   int   fv_prev  = -1;

   tdm_demux8 #(
      .MISS_LIMIT (MISS_LIMIT),
      .ERR_W      (ERR_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .din         (din),
      .sync        (sync),
      .q           (q),
      .frame_valid (frame_valid),
      .locked      (locked),
      .slot        (slot),
      .sync_err    (sync_err),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // One clock: drive at negedge, sample 1 time unit after the rising edge.
   task automatic step(input logic e, input logic d, input logic s);
      exp_t x;
      logic exp_fv;
      @(negedge clk);
      rst  = 1'b0;
      en   = e;
      din  = d;
      sync = s;
      @(posedge clk);
      #1;
      cyc++;
      exp_fv = (sb.size() > 0) && (sb[0].due == cyc);
      chk("frame_valid", frame_valid, exp_fv);
      if (exp_fv) begin
         x = sb.pop_front();
         chk("q", q, x.val);
         $display("cyc=%0d frame q=%b expected=%b", cyc, q, x.val);
      end
      if (frame_valid) begin
         fv_prev = fv_last;
         fv_last = cyc;
      end
      if (sync_err) se_count++;
   endtask

   // Send one 8-slot frame; optional en=0 gap after slot 4.
   task automatic send_frame(input logic [7:0] bits, input logic s0,
                             input bit push, input int gap);
      exp_t x;
      if (push) begin
         x.due = cyc + 8 + gap;
         x.val = bits;
         sb.push_back(x);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, bits[i], (i == 0) ? s0 : 1'b0);
         if (i == 4) begin
            for (int g = 0; g < gap; g++) begin
               step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
         end
      end
   endtask

   task automatic do_rst();
      @(negedge clk);
      rst  = 1'b1;
      en   = 1'b1;
      din  = 1'b1;
      sync = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_q", q, 8'h00);
      chk("rst_frame_valid", frame_valid, 1'b0);
      chk("rst_locked", locked, 1'b0);
      chk("rst_slot", slot, 3'd0);
      chk("rst_sync_err", sync_err, 1'b0);
      chk("rst_err_count", err_count, 2'd0);
      $display("cyc=%0d reset q=%b locked=%b slot=%0d err_count=%0d", cyc, q, locked, slot, err_count);
   endtask

   initial begin
      logic [7:0] f0, f1, f2, f3, f4, f5, f6;
      exp_t x;
      int   se0;
      int   sync_cyc;

      f0 = 8'b01001101;
      f1 = 8'b11100010;
      f2 = 8'b00111001;
      f3 = 8'b10010111;
      f4 = 8'b01101100;
      f5 = 8'b11011010;
      f6 = 8'b10110110;
      rst = 1'b1; en = 1'b0; din = 1'b0; sync = 1'b0;

      do_rst();

      // Hunting: data without marker is ignored
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      chk("hunt_locked", locked, 1'b0);
      chk("hunt_slot", slot, 3'd0);

      // Acquire and decode first frame
      x.due = cyc + 8;
      x.val = f0;
      sb.push_back(x);
      step(1'b1, f0[0], 1'b1);
      sync_cyc = cyc;
      chk("acq_locked", locked, 1'b1);
      chk("acq_slot", slot, 3'd1);
      for (int i = 1; i < 8; i++) step(1'b1, f0[i], 1'b0);
      chk("acq_fv_latency", fv_last - sync_cyc, 7);
      chk("wrap_slot", slot, 3'd0);

      send_frame(f0, 1'b1, 1, 0);
      send_frame(f0, 1'b1, 1, 0);
      chk("fv_spacing", fv_last - fv_prev, 8);

      // en gap of 3 cycles after slot 4
      se0 = se_count;
      sync_cyc = cyc + 1;
      send_frame(f0, 1'b1, 1, 3);
      chk("gap_fv_latency", fv_last - sync_cyc, 10);
      chk("gap_no_sync_err", se_count - se0, 0);
      chk("gap_err_count", err_count, 2'd0);

      // One missing marker: error, frame still delivered
      se0 = se_count;
      send_frame(f1, 1'b0, 1, 0);
      chk("miss1_sync_err", se_count - se0, 1);
      chk("miss1_err_count", err_count, 2'd1);
      chk("miss1_locked", locked, 1'b1);
      send_frame(f0, 1'b1, 1, 0);

      // Two consecutive misses: second one drops lock and its frame
      se0 = se_count;
      send_frame(f2, 1'b0, 1, 0);
      send_frame(f3, 1'b0, 0, 0);
      chk("miss2_sync_err", se_count - se0, 2);
      chk("miss2_err_count", err_count, 2'd3);
      chk("miss2_locked", locked, 1'b0);

      // Reacquire, then early marker on slot 5
      send_frame(f0, 1'b1, 1, 0);
      se0 = se_count;
      for (int i = 0; i < 5; i++) step(1'b1, f1[i], (i == 0) ? 1'b1 : 1'b0);
      sync_cyc = cyc + 1;
      send_frame(f4, 1'b1, 1, 0);
      chk("early_sync_err", se_count - se0, 1);
      chk("early_fv_latency", fv_last - sync_cyc, 7);
      chk("err_count_sat_hold", err_count, 2'd3);

      // Early marker on slot 7 suppresses that frame
      se0 = se_count;
      for (int i = 0; i < 7; i++) step(1'b1, f2[i], (i == 0) ? 1'b1 : 1'b0);
      chk("q_hold", q, f4);
      send_frame(f5, 1'b1, 1, 0);
      chk("early7_sync_err", se_count - se0, 1);

      // Saturation of the error counter from zero
      do_rst();
      step(1'b1, 1'b0, 1'b1);
      chk("sat_acq_err", err_count, 2'd0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b1);
         chk("sat_sync_err", sync_err, 1'b1);
         chk("sat_err_count", err_count, (i < 3) ? 32'(i + 1) : 32'd3);
         $display("cyc=%0d early marker err_count=%0d", cyc, err_count);
      end
      x.due = cyc + 7;
      x.val = f6;
      sb.push_back(x);
      for (int i = 1; i < 8; i++) step(1'b1, f6[i], 1'b0);
      chk("sat_frame_q", q, f6);

      // Reset mid-frame (at slot 4)
      for (int i = 0; i < 4; i++) step(1'b1, f0[i], (i == 0) ? 1'b1 : 1'b0);
      chk("pre_rst_slot", slot, 3'd4);
      do_rst();
      for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      chk("post_rst_locked", locked, 1'b0);
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
